multiwave_osc: RTL and testbench
================================

// Module: multiwave_osc
// PURPOSE
//  Parametrised multi-voice waveform generator: maps a per-voice phase word to a signed sample.
//  Replaces the single-waveform 2-cycle wavetable stage between the phase accumulator and voice mixer.
//  Fully pipelined, one request per cycle, valid/ready on both sides, voice tag carried alongside.
//  Waveforms: quarter-wave sine ROM, square, saw, triangle, LFSR noise, silence.
// PARAMETERS
//  PHASE_W   10  phase input width (>=4); sine ROM depth Q = 2^(PHASE_W-2)
//  SAMPLE_W  16  signed sample width (2..16); MAX = 2^(SAMPLE_W-1)-1
//  VOICE_W   8   voice tag width
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high
//  in_valid     in   1         request valid
//  in_ready     out  1         request accepted when in_valid && in_ready
//  phase        in   PHASE_W   unsigned phase, 0..2^PHASE_W-1 = one period
//  wave_select  in   4         0 sine, 1 square, 2 saw, 3 triangle, 4 noise, 5..15 silence
//  voice_index  in   VOICE_W   voice tag, returned unchanged with the sample
//  pulse_width  in   PHASE_W   square duty threshold (WAVE_PWM_EN builds only)
//  out_valid    out  1         sample/voice_index_out valid
//  out_ready    in   1         downstream accepts when out_valid && out_ready
//  sample       out  SAMPLE_W  signed sample
//  voice_index_out out VOICE_W tag of the request that produced sample
// BEHAVIOUR
//  - One clock (clk), reset synchronous and active-high (reset).
//  - Reset: out_valid=0, sample=0, voice_index_out=0, all stage valids cleared, LFSR=16'hACE1.
//    Reset mid-operation drops every in-flight request; no output for them afterwards.
//  - Pipeline: S1 register inputs + ROM address; S2 ROM read + waveform compute; S3 output register.
//    Latency exactly 3 cycles from accept to out_valid with out_ready held high; throughput 1/cycle.
//  - Stall: stall = out_valid && !out_ready. While stalled all stages hold, in_ready=0,
//    sample/voice_index_out stable. in_ready = !stall (combinational). Bubbles are not compressed.
//  - Order preserved; voice_index_out always pairs with its own sample.
//  - Sine: sign = phase[P-1]; mirror = phase[P-2]; idx = mirror ? ~phase[P-3:0] : phase[P-3:0].
//    ROM[k] = round(MAX*sin(pi/2*(k+0.5)/Q)); sample = sign ? -ROM[idx] : ROM[idx]. Never -2^(S-1).
//  - Square: phase < 2^(P-1) -> +MAX else -MAX (symmetric, never -2^(S-1)).
//  - Saw: phase left-aligned into SAMPLE_W (zero-fill LSBs, or drop LSBs if P>S), MSB inverted.
//  - Triangle: t = phase[P-1] ? ~phase[P-2:0] : phase[P-2:0]; t left-aligned into SAMPLE_W, MSB inverted.
//  - Noise: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1; advances only on accepted noise
//    requests (no advance when stalled); sample = top SAMPLE_W LFSR bits (value before the advance).
//  - Silence: sample = 0. Unused codes never produce X.
// CONFIGURATION
//  WAVE_PWM_EN defined: pulse_width port exists, sampled with phase in S1;
//    square = (phase < pulse_width) ? +MAX : -MAX; pulse_width=0 -> constant -MAX.
//  WAVE_PWM_EN undefined: no pulse_width port; square fixed 50% duty as above.
// TESTING (PHASE_W=10, SAMPLE_W=16; out_ready=1 unless stated)
//  - Reset, then sine phase 0/256/512/768 back-to-back -> 101, 32767, -101, -32767 on 4 consecutive
//    cycles, first 3 cycles after first accept; voice tags 7,8,9,10 returned in order.
//  - Square 511 -> +32767, 512 -> -32767; saw 0 -> -32768, 1023 -> 32704;
//    triangle 0 -> -32768, 511 -> 32640, 512 -> 32640, 1023 -> -32768; select 9 -> 0.
//  - Stream 8 requests, drop out_ready for 5 cycles mid-stream -> in_ready=0 while stalled,
//    sample held, no loss/duplication, order intact after release.
//  - Noise x3 after reset with a stall between -> 16'hACE1 then two successive LFSR states; stall
//    does not advance LFSR.
//  - Assert reset with 3 requests in flight -> out_valid=0 next cycle, sample=0, none emerge later.
//  - WAVE_PWM_EN: pulse_width=256, square phase 255 -> +32767, 256 -> -32767; pulse_width=0 -> -32767.

Source files
------------

// File: rtl/multiwave_osc_if.sv
// multiwave_osc_if: request/response bus of the multi-voice waveform generator.
// Request side: in_valid/in_ready, phase, wave_select, voice_index (+ pulse_width when
// WAVE_PWM_EN is defined). Response side: out_valid/out_ready, sample, voice_index_out.
interface multiwave_osc_if #(
  parameter int PHASE_W  = 10,
  parameter int SAMPLE_W = 16,
  parameter int VOICE_W  = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [PHASE_W-1:0]         phase;
  logic [3:0]                 wave_select;
  logic [VOICE_W-1:0]         voice_index;
`ifdef WAVE_PWM_EN
  logic [PHASE_W-1:0]         pulse_width;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] sample;
  logic [VOICE_W-1:0]         voice_index_out;

`ifdef WAVE_PWM_EN
  modport master (
    output in_valid, phase, wave_select, voice_index, pulse_width, out_ready,
    input  in_ready, out_valid, sample, voice_index_out
  );
  modport slave (
    input  in_valid, phase, wave_select, voice_index, pulse_width, out_ready,
    output in_ready, out_valid, sample, voice_index_out
  );
`else
  modport master (
    output in_valid, phase, wave_select, voice_index, out_ready,
    input  in_ready, out_valid, sample, voice_index_out
  );
  modport slave (
    input  in_valid, phase, wave_select, voice_index, out_ready,
    output in_ready, out_valid, sample, voice_index_out
  );
`endif
endinterface

// File: rtl/multiwave_osc.sv
// multiwave_osc: 3-stage pipelined multi-voice waveform generator.
// Maps a per-voice phase word to a signed sample (sine, square, saw, triangle, noise, silence).
// S1 registers the request and the quarter-wave ROM address, S2 reads the ROM and computes
// the selected waveform, S3 is the output register. Whole pipeline freezes on output stall.
// Optional feature macro: WAVE_PWM_EN (adds pulse_width, variable square duty).
module multiwave_osc #(
  parameter int PHASE_W  = 10,
  parameter int SAMPLE_W = 16,
  parameter int VOICE_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  multiwave_osc_if.slave bus
);

  localparam int IDX_W     = PHASE_W - 2;
  localparam int ROM_DEPTH = 2 ** IDX_W;
  localparam logic signed [SAMPLE_W-1:0] MAX_S = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  WAVE_SINE   = 4'd0;
  localparam logic [3:0]  WAVE_SQUARE = 4'd1;
  localparam logic [3:0]  WAVE_SAW    = 4'd2;
  localparam logic [3:0]  WAVE_TRI    = 4'd3;
  localparam logic [3:0]  WAVE_NOISE  = 4'd4;
  localparam real PI = 3.14159265358979323846;

  // Quarter-wave entry k, sampled at the bin centre so the table is symmetric.
  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int k);
    real angle;
    real mag;
    angle = PI * (real'(k) + 0.5) / (2.0 * real'(ROM_DEPTH));
    mag   = real'(MAX_S) * $sin(angle);
    return SAMPLE_W'($rtoi(mag + 0.5));
  endfunction

  // Handshake
  logic                       stall_s;
  logic                       accept_s;

  // Stage 1
  logic                       s1_valid_q;
  logic [3:0]                 s1_wave_q;
  logic [PHASE_W-1:0]         s1_phase_q;
  logic [VOICE_W-1:0]         s1_voice_q;
  logic [IDX_W-1:0]           s1_idx_q;
  logic [SAMPLE_W-1:0]        s1_noise_q;
`ifdef WAVE_PWM_EN
  logic [PHASE_W-1:0]         s1_pw_q;
`endif
  logic [IDX_W-1:0]           idx_d;

  // Noise generator
  logic [15:0]                lfsr_q;
  logic [15:0]                lfsr_d;

  // Stage 2
  logic                       s2_valid_q;
  logic signed [SAMPLE_W-1:0] s2_sample_q;
  logic [VOICE_W-1:0]         s2_voice_q;

  // Stage 3 (output)
  logic                       out_valid_q;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic [VOICE_W-1:0]         voice_out_q;

  // Waveform datapath
  logic signed [SAMPLE_W-1:0] rom_s [ROM_DEPTH];
  logic signed [SAMPLE_W-1:0] sine_mag_s;
  logic signed [SAMPLE_W-1:0] sine_s;
  logic signed [SAMPLE_W-1:0] square_s;
  logic signed [SAMPLE_W-1:0] saw_s;
  logic signed [SAMPLE_W-1:0] tri_s;
  logic signed [SAMPLE_W-1:0] wave_d;
  logic [SAMPLE_W-1:0]        saw_raw_s;
  logic [SAMPLE_W-1:0]        tri_raw_s;
  logic [PHASE_W-2:0]         tri_t_s;
  logic                       square_pos_s;

  assign stall_s  = out_valid_q & ~bus.out_ready;
  assign accept_s = bus.in_valid & ~stall_s;

  assign bus.in_ready        = ~stall_s;
  assign bus.out_valid       = out_valid_q;
  assign bus.sample          = sample_q;
  assign bus.voice_index_out = voice_out_q;

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    assign rom_s[k] = sine_entry(k);
  end

  // Saw: left-align the phase into the sample width (pad or truncate LSBs).
  if (PHASE_W >= SAMPLE_W) begin : g_saw_trunc
    assign saw_raw_s = s1_phase_q[PHASE_W-1 -: SAMPLE_W];
  end else begin : g_saw_pad
    assign saw_raw_s = {s1_phase_q, {(SAMPLE_W-PHASE_W){1'b0}}};
  end

  // Triangle: left-align the folded phase the same way.
  if (PHASE_W - 1 >= SAMPLE_W) begin : g_tri_trunc
    assign tri_raw_s = tri_t_s[PHASE_W-2 -: SAMPLE_W];
  end else begin : g_tri_pad
    assign tri_raw_s = {tri_t_s, {(SAMPLE_W-PHASE_W+1){1'b0}}};
  end

  // Quarter-wave ROM address: mirror the index in the second half of each half-period.
  always_comb begin
    idx_d = bus.phase[IDX_W-1:0];
    if (bus.phase[PHASE_W-2]) begin
      idx_d = ~bus.phase[IDX_W-1:0];
    end else begin
      idx_d = bus.phase[IDX_W-1:0];
    end
  end

  // Galois LFSR step, taken only when a noise request is actually accepted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_s && (bus.wave_select == WAVE_NOISE)) begin
      if (lfsr_q[0]) begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ LFSR_TAPS;
      end else begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // S2 waveform compute from the registered request; unknown codes give silence.
  always_comb begin
    sine_mag_s = rom_s[s1_idx_q];
    if (s1_phase_q[PHASE_W-1]) begin
      sine_s = -sine_mag_s;
    end else begin
      sine_s = sine_mag_s;
    end
`ifdef WAVE_PWM_EN
    square_pos_s = (s1_phase_q < s1_pw_q);
`else
    square_pos_s = ~s1_phase_q[PHASE_W-1];
`endif
    if (square_pos_s) begin
      square_s = MAX_S;
    end else begin
      square_s = -MAX_S;
    end
    if (s1_phase_q[PHASE_W-1]) begin
      tri_t_s = ~s1_phase_q[PHASE_W-2:0];
    end else begin
      tri_t_s = s1_phase_q[PHASE_W-2:0];
    end
    saw_s = {~saw_raw_s[SAMPLE_W-1], saw_raw_s[SAMPLE_W-2:0]};
    tri_s = {~tri_raw_s[SAMPLE_W-1], tri_raw_s[SAMPLE_W-2:0]};
    case (s1_wave_q)
      WAVE_SINE:   wave_d = sine_s;
      WAVE_SQUARE: wave_d = square_s;
      WAVE_SAW:    wave_d = saw_s;
      WAVE_TRI:    wave_d = tri_s;
      WAVE_NOISE:  wave_d = s1_noise_q;
      default:     wave_d = '0;
    endcase
  end

  // Pipeline and noise state: everything advances together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_wave_q   <= 4'd0;
      s1_phase_q  <= '0;
      s1_voice_q  <= '0;
      s1_idx_q    <= '0;
      s1_noise_q  <= '0;
`ifdef WAVE_PWM_EN
      s1_pw_q     <= '0;
`endif
      s2_valid_q  <= 1'b0;
      s2_sample_q <= '0;
      s2_voice_q  <= '0;
      out_valid_q <= 1'b0;
      sample_q    <= '0;
      voice_out_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else if (!stall_s) begin
      s1_valid_q  <= accept_s;
      s1_wave_q   <= bus.wave_select;
      s1_phase_q  <= bus.phase;
      s1_voice_q  <= bus.voice_index;
      s1_idx_q    <= idx_d;
      s1_noise_q  <= lfsr_q[15 -: SAMPLE_W];
`ifdef WAVE_PWM_EN
      s1_pw_q     <= bus.pulse_width;
`endif
      s2_valid_q  <= s1_valid_q;
      s2_sample_q <= wave_d;
      s2_voice_q  <= s1_voice_q;
      out_valid_q <= s2_valid_q;
      sample_q    <= s2_sample_q;
      voice_out_q <= s2_voice_q;
      lfsr_q      <= lfsr_d;
    end else begin
      lfsr_q      <= lfsr_q;
    end
  end

endmodule

// File: tb/tb_multiwave_osc.sv
// tb_multiwave_osc: scoreboard bench for multiwave_osc (PHASE_W=10, SAMPLE_W=16).
// Expected samples are pushed when a request is accepted and popped when the DUT emits.
module tb_multiwave_osc;
  localparam int PW = 10;
  localparam int SW = 16;
  localparam int VW = 8;

  typedef struct {
    int smp;
    int voice;
    int acc_cyc;
    bit lat_chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  logic [15:0] lfsr_m;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  multiwave_osc_if #(.PHASE_W(PW), .SAMPLE_W(SW), .VOICE_W(VW)) bus ();

  multiwave_osc #(.PHASE_W(PW), .SAMPLE_W(SW), .VOICE_W(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    if (x[0]) return {1'b0, x[15:1]} ^ 16'hB400;
    else      return {1'b0, x[15:1]};
  endfunction

  function automatic int saw_ref(input int ph);
    logic [9:0]  p;
    logic [15:0] v;
    p = 10'(ph);
    v = {p, 6'd0} ^ 16'h8000;
    return int'($signed(v));
  endfunction

  function automatic int tri_ref(input int ph);
    logic [9:0]  p;
    logic [8:0]  t;
    logic [15:0] v;
    p = 10'(ph);
    t = p[9] ? ~p[8:0] : p[8:0];
    v = {t, 7'd0} ^ 16'h8000;
    return int'($signed(v));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop on every handshake, check hold/backpressure while stalled.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", bus.out_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("sample", bus.sample, mon_e.smp);
        check_val("voice", bus.voice_index_out, mon_e.voice);
        if (mon_e.lat_chk) check_val("latency", cyc - mon_e.acc_cyc, 3);
      end
    end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
      check_val("stall_in_ready", bus.in_ready, 0);
      if (sb.size() != 0) check_val("stall_hold", bus.sample, sb[0].smp);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lfsr_m = 16'hACE1;
  endtask

  // Drive one request; called at posedge+1, returns at posedge+1 after the accept edge.
  task automatic send(input int wave, input int ph, input int voice, input int exp_smp,
                      input bit track, input bit lat);
    int   waited;
    int   acc;
    int   e;
    logic ok;
    waited = 0;
    ok     = 1'b0;
    e      = exp_smp;
    bus.in_valid    = 1'b1;
    bus.wave_select = 4'(wave);
    bus.phase       = PW'(ph);
    bus.voice_index = VW'(voice);
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check_val("accept_timeout", bus.in_ready, 1);
    end else begin
      acc = cyc;
      if (wave == 4) begin
        e      = int'($signed(lfsr_m));
        lfsr_m = lfsr_next(lfsr_m);
      end
      if (track) sb.push_back('{e, voice, acc, lat});
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_empty", sb.size(), 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.phase       = '0;
    bus.wave_select = 4'd0;
    bus.voice_index = '0;
    bus.out_ready   = 1'b1;
`ifdef WAVE_PWM_EN
    bus.pulse_width = 10'd512;
`endif
    do_reset();

    // Reset state
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_sample", bus.sample, 0);
    check_val("rst_voice", bus.voice_index_out, 0);
    check_val("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Sine quadrant points back-to-back, latency checked
    send(0, 0,   7,  101,    1, 1);
    send(0, 256, 8,  32767,  1, 1);
    send(0, 512, 9,  -101,   1, 1);
    send(0, 768, 10, -32767, 1, 1);

    // Square, saw, triangle, silence
    send(1, 511,  11, 32767,  1, 0);
    send(1, 512,  12, -32767, 1, 0);
    send(2, 0,    13, -32768, 1, 0);
    send(2, 1023, 14, 32704,  1, 0);
    send(3, 0,    15, -32768, 1, 0);
    send(3, 511,  16, 32640,  1, 0);
    send(3, 512,  17, 32640,  1, 0);
    send(3, 1023, 18, -32768, 1, 0);
    send(9, 300,  19, 0,      1, 0);
    drain();

    // Stream of 8 with a 5-cycle output stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 0) send(2, i * 131, 20 + i, saw_ref(i * 131), 1, 0);
          else            send(3, i * 131, 20 + i, tri_ref(i * 131), 1, 0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Noise: stall between requests must not advance the LFSR
    do_reset();
    send(4, 0, 30, 0, 1, 0);
    bus.out_ready = 1'b0;
    send(4, 0, 31, 0, 1, 0);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 send(4, 0, 32, 0, 1, 0);
      end
      begin
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check_val("lfsr_model_state", lfsr_m, 16'h389C);

`ifdef WAVE_PWM_EN
    // Variable duty square
    bus.pulse_width = 10'd256;
    send(1, 255, 40, 32767,  1, 0);
    send(1, 256, 41, -32767, 1, 0);
    bus.pulse_width = 10'd0;
    send(1, 0,   42, -32767, 1, 0);
    bus.pulse_width = 10'd512;
    drain();
`endif

    // Reset with three requests in flight: only the one already at the output is delivered
    send(0, 0,   50, 101, 1, 0);
    send(0, 256, 51, 0,   0, 0);
    send(0, 512, 52, 0,   0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_sample", bus.sample, 0);
    check_val("midrst_voice", bus.voice_index_out, 0);
    repeat (10) @(posedge clk);
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
